// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its three requesters (IF, DM, loader)
// and the single-port memory macro.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_rvalid;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_mode;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [15:0]       perf_conflicts;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rdata, if_rvalid,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rdata, dm_rvalid,
    input  ld_req, ld_addr, ld_wdata,
    output ld_gnt, ld_mode,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output perf_conflicts
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rdata, if_rvalid,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rdata, dm_rvalid,
    output ld_req, ld_addr, ld_wdata,
    input  ld_gnt, ld_mode,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  perf_conflicts
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter for the unified IF/DM memory with IF starvation guard
// and post-reset LOAD mode. Define ARB_PERF_CNT_EN to build the perf_conflicts counter.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk1,
  input  logic        reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state;
  state_t            state_nxt;
  owner_t            rd_owner;
  logic [3:0]        starve_cnt;
  logic              if_gnt;
  logic              dm_gnt;
  logic              ld_gnt;
  logic              if_rvalid;
  logic              dm_rvalid;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  always_ff @(posedge clk1) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (bus.ld_req) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_LOAD;
      ST_LOAD:  if (!bus.ld_req) state_nxt = ST_RUN;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  // Grants are held off during reset so no memory access slips through.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (!bus.ld_req) begin
            if (bus.if_req && starve_cnt == STARVE_LIM) if_gnt = 1'b1;
            else if (bus.dm_req)                        dm_gnt = 1'b1;
            else if (bus.if_req)                        if_gnt = 1'b1;
          end
        end
        ST_LOAD: ld_gnt = bus.ld_req;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (reset || state == ST_LOAD) begin
      starve_cnt <= '0;
    end else if (bus.if_req && !if_gnt) begin
      if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      rd_owner   <= OWN_NONE;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= bus.mem_rdata;
      if (dm_rvalid) dm_rdata_q <= bus.mem_rdata;
      if (if_gnt)                    rd_owner <= OWN_IF;
      else if (dm_gnt && !bus.dm_we) rd_owner <= OWN_DM;
      else                           rd_owner <= OWN_NONE;
    end
  end

  // Read data is passed straight through in the rvalid cycle and held afterwards.
  always_comb begin
    if_rvalid     = !reset && (rd_owner == OWN_IF);
    dm_rvalid     = !reset && (rd_owner == OWN_DM);
    bus.if_rvalid = if_rvalid;
    bus.dm_rvalid = dm_rvalid;
    bus.if_rdata  = if_rvalid ? bus.mem_rdata : if_rdata_q;
    bus.dm_rdata  = dm_rvalid ? bus.mem_rdata : dm_rdata_q;
    bus.if_gnt    = if_gnt;
    bus.dm_gnt    = dm_gnt;
    bus.ld_gnt    = ld_gnt;
    bus.ld_mode   = (state == ST_LOAD);
  end

  always_comb begin
    bus.mem_en    = if_gnt | dm_gnt | ld_gnt;
    bus.mem_we    = ld_gnt | (dm_gnt & bus.dm_we);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (ld_gnt) begin
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_wdata;
    end else if (dm_gnt) begin
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_we ? bus.dm_wdata : '0;
    end else if (if_gnt) begin
      bus.mem_addr  = bus.if_addr;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk1) begin
    if (reset)
      perf_cnt <= '0;
    else if (state == ST_RUN && bus.if_req && bus.dm_req && perf_cnt != '1)
      perf_cnt <= perf_cnt + 16'd1;
  end

  assign bus.perf_conflicts = perf_cnt;
`else
  assign bus.perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences,
// then random traffic against a cycle-level reference model.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 3;

  logic clk1 = 1'b0;
  logic reset = 1'b1;
  always #5 clk1 = ~clk1;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous single-port memory macro.
  logic [31:0] mem [256] = '{default: '0};
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        ld_req;
    logic [7:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic [2:0]  e_gnt;     // {ld, dm, if}
    logic        e_ld_mode;
    logic [1:0]  e_rv;      // {if, dm}
    logic [31:0] e_rdata;
  } vec_t;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  bit          m_load  = 1'b1;
  bit          m_drain = 1'b0;
  int unsigned m_starve = 0;
  int unsigned m_pend   = 0;   // 0 none, 1 IF, 2 DM
  logic [31:0] m_pend_data = '0;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_dm_rd = '0;
  logic [31:0] m_shadow [256] = '{default: '0};
  int unsigned m_perf = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic ifr, input logic [7:0] ifa,
                              input logic dmr, input logic dmwe, input logic [7:0] dma,
                              input logic [31:0] dmwd, input logic ldr, input logic [7:0] lda,
                              input logic [31:0] ldwd, input logic [2:0] eg, input logic elm,
                              input logic [1:0] erv, input logic [31:0] erd);
    vec_t v;
    v.rst = rst; v.if_req = ifr; v.if_addr = ifa;
    v.dm_req = dmr; v.dm_we = dmwe; v.dm_addr = dma; v.dm_wdata = dmwd;
    v.ld_req = ldr; v.ld_addr = lda; v.ld_wdata = ldwd;
    v.e_gnt = eg; v.e_ld_mode = elm; v.e_rv = erv; v.e_rdata = erd;
    return v;
  endfunction

  task automatic step(input vec_t v, input bit chk, input bit use_tbl);
    bit g_if, g_dm, g_ld, e_en, e_we, e_ifv, e_dmv;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata, e_ifd, e_dmd;
    logic [15:0] e_perf;
    @(negedge clk1);
    reset = v.rst;
    bus.if_req = v.if_req; bus.if_addr = v.if_addr;
    bus.dm_req = v.dm_req; bus.dm_we = v.dm_we; bus.dm_addr = v.dm_addr; bus.dm_wdata = v.dm_wdata;
    bus.ld_req = v.ld_req; bus.ld_addr = v.ld_addr; bus.ld_wdata = v.ld_wdata;
    #1;
    g_if = 0; g_dm = 0; g_ld = 0;
    if (!v.rst) begin
      if (m_load) g_ld = v.ld_req;
      else if (!m_drain && !v.ld_req) begin
        if (v.if_req && m_starve >= STARVE_MAX) g_if = 1;
        else if (v.dm_req)                      g_dm = 1;
        else if (v.if_req)                      g_if = 1;
      end
    end
    e_en    = g_if | g_dm | g_ld;
    e_we    = g_ld | (g_dm & v.dm_we);
    e_addr  = g_ld ? v.ld_addr : g_dm ? v.dm_addr : v.if_addr;
    e_wdata = g_ld ? v.ld_wdata : v.dm_wdata;
    e_ifv   = !v.rst && m_pend == 1;
    e_dmv   = !v.rst && m_pend == 2;
    e_ifd   = e_ifv ? m_pend_data : m_if_rd;
    e_dmd   = e_dmv ? m_pend_data : m_dm_rd;
`ifdef ARB_PERF_CNT_EN
    e_perf  = 16'(m_perf);
`else
    e_perf  = 16'h0;
`endif
    if (chk) begin
      check("grant", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, {g_ld, g_dm, g_if});
      check("ld_mode", bus.ld_mode, m_load);
      check("if_rvalid", bus.if_rvalid, e_ifv);
      check("dm_rvalid", bus.dm_rvalid, e_dmv);
      check("if_rdata", bus.if_rdata, e_ifd);
      check("dm_rdata", bus.dm_rdata, e_dmd);
      check("mem_en", bus.mem_en, e_en);
      check("mem_we", bus.mem_we, e_we);
      if (e_en) check("mem_addr", bus.mem_addr, e_addr);
      if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
      check("perf_conflicts", bus.perf_conflicts, e_perf);
      if (use_tbl) begin
        check("tbl_grant", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, v.e_gnt);
        check("tbl_ld_mode", bus.ld_mode, v.e_ld_mode);
        check("tbl_rvalid", {bus.if_rvalid, bus.dm_rvalid}, v.e_rv);
        if (v.e_rv[1]) check("tbl_if_rdata", bus.if_rdata, v.e_rdata);
        if (v.e_rv[0]) check("tbl_dm_rdata", bus.dm_rdata, v.e_rdata);
      end
    end
    // Advance the model across the coming clock edge.
    if (v.rst) begin
      m_load = 1; m_drain = 0; m_starve = 0; m_pend = 0;
      m_if_rd = '0; m_dm_rd = '0; m_perf = 0;
    end else begin
      if (e_ifv) m_if_rd = m_pend_data;
      if (e_dmv) m_dm_rd = m_pend_data;
      m_pend = g_if ? 1 : (g_dm && !v.dm_we) ? 2 : 0;
      if (m_pend != 0) m_pend_data = m_shadow[e_addr];
      if (e_we) m_shadow[e_addr] = e_wdata;
      if (!m_load && !m_drain && v.if_req && v.dm_req && m_perf < 65535) m_perf++;
      if (m_load) m_starve = 0;
      else if (v.if_req && !g_if) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      else m_starve = 0;
      if (m_load) m_load = v.ld_req;
      else if (m_drain) begin m_drain = 0; m_load = 1; end
      else if (v.ld_req) m_drain = 1;
    end
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
    idle = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 3'b000, 0, 2'b00, 0);

    //           rst if  ifa    dm we dma    dmwd        ld lda    ldwd      gnt   lm rv     rdata
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0,          0, 8'h00, 0,        3'b000, 1, 2'b00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,          1, 8'h00, 32'hA0,   3'b100, 1, 2'b00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,          1, 8'h01, 32'hA1,   3'b100, 1, 2'b00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,          1, 8'h02, 32'hA2,   3'b100, 1, 2'b00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,          1, 8'h03, 32'hA3,   3'b100, 1, 2'b00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,          0, 8'h00, 0,        3'b000, 1, 2'b00, 0));
    tbl.push_back(mk(0, 1, 8'h02, 0, 0, 8'h00, 0,          0, 8'h00, 0,        3'b001, 0, 2'b00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,          0, 8'h00, 0,        3'b000, 0, 2'b10, 32'hA2));
    tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h01, 0,          0, 8'h00, 0,        3'b010, 0, 2'b00, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h01, 0,          0, 8'h00, 0,        3'b010, 0, 2'b01, 32'hA1));
    tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h01, 0,          0, 8'h00, 0,        3'b010, 0, 2'b01, 32'hA1));
    tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h01, 0,          0, 8'h00, 0,        3'b001, 0, 2'b01, 32'hA1));
    tbl.push_back(mk(0, 1, 8'h00, 1, 0, 8'h01, 0,          0, 8'h00, 0,        3'b010, 0, 2'b10, 32'hA0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,          0, 8'h00, 0,        3'b000, 0, 2'b01, 32'hA1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h10, 32'h1234,   0, 8'h00, 0,        3'b010, 0, 2'b00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h10, 0,          0, 8'h00, 0,        3'b010, 0, 2'b00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,          0, 8'h00, 0,        3'b000, 0, 2'b01, 32'h1234));
    tbl.push_back(mk(0, 1, 8'h03, 0, 0, 8'h00, 0,          0, 8'h00, 0,        3'b001, 0, 2'b00, 0));
    tbl.push_back(mk(0, 1, 8'h03, 1, 0, 8'h01, 0,          1, 8'h20, 32'h55,   3'b000, 0, 2'b10, 32'hA3));
    tbl.push_back(mk(0, 1, 8'h03, 1, 0, 8'h01, 0,          1, 8'h20, 32'h55,   3'b000, 0, 2'b00, 0));
    tbl.push_back(mk(0, 1, 8'h03, 1, 0, 8'h01, 0,          1, 8'h20, 32'h55,   3'b100, 1, 2'b00, 0));
    tbl.push_back(mk(0, 1, 8'h03, 1, 0, 8'h20, 0,          0, 8'h00, 0,        3'b000, 1, 2'b00, 0));
    tbl.push_back(mk(0, 1, 8'h03, 1, 0, 8'h20, 0,          0, 8'h00, 0,        3'b010, 0, 2'b00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,          0, 8'h00, 0,        3'b000, 0, 2'b01, 32'h55));

    step(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 3'b000, 1, 2'b00, 0), 0, 0);
    foreach (tbl[i]) step(tbl[i], 1, 1);

    // Reset landing right after an IF grant drops the pending rvalid.
    step(mk(0, 1, 8'h02, 0, 0, 8'h00, 0, 0, 8'h00, 0, 3'b001, 0, 2'b00, 0), 1, 1);
    step(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 3'b000, 0, 2'b00, 0), 1, 1);
    check("rst_drop_rvalid", bus.if_rvalid, 1'b0);
    step(idle, 1, 0);
    check("rst_enters_load", bus.ld_mode, 1'b1);
    check("rst_perf_clear", bus.perf_conflicts, 16'h0);

    // Ten RUN cycles of IF/DM contention.
    for (int i = 0; i < 10; i++)
      step(mk(0, 1, 8'h01, 1, 0, 8'h02, 0, 0, 8'h00, 0, 3'b000, 0, 2'b00, 0), 1, 0);
    step(idle, 1, 0);
`ifdef ARB_PERF_CNT_EN
    check("perf_10", bus.perf_conflicts, 16'd10);
`else
    check("perf_tied_0", bus.perf_conflicts, 16'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      vec_t r;
      r = idle;
      r.rst      = ($urandom_range(0, 99) == 0);
      r.if_req   = ($urandom_range(0, 9) < 6);
      r.if_addr  = 8'($urandom_range(0, 15));
      r.dm_req   = ($urandom_range(0, 9) < 6);
      r.dm_we    = $urandom_range(0, 1) == 1;
      r.dm_addr  = 8'($urandom_range(0, 15));
      r.dm_wdata = $urandom;
      r.ld_req   = ($urandom_range(0, 9) == 0);
      r.ld_addr  = 8'($urandom_range(0, 15));
      r.ld_wdata = $urandom;
      step(r, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
